// File: rtl/misao_mem_arbiter.sv
// -----------------------------------------------------------------------------
// misao_mem_arbiter
//
// Shares one byte-wide memory between the misao core port and a host/loader
// port (debug, DMA, program load). The core owns the bus with no wait states
// while the host is idle. A waiting host is granted on the first cycle the
// core is idle. If the core stays busy, the host is forced in after
// STARVE_MAX wait cycles, and the core is stalled for that one cycle.
//
// Memory reads are combinational (mem_rdata follows mem_addr). Writes are
// performed by the memory on the posedge while mem_en_write is high.
//
// Optional feature macro: ARB_STATS_EN
//   defined   : stat_grants / stat_stalls are saturating 16-bit counters.
//   undefined : both stat outputs are tied to zero (no counter flops).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   core_en_read/_write      core strobes (both may be high together)
//   core_addr, core_wdata    core address / write data
//   core_rdata               read data to core (= mem_rdata)
//   core_stall               core must hold its request this cycle
//   host_req                 host request, held until host_ack
//   host_we                  1 = write, 0 = read (stable while host_req)
//   host_addr, host_wdata    host address / write data (stable while host_req)
//   host_ack                 one-cycle completion pulse
//   host_rdata               registered host read data
//   mem_en_read/_write       strobes to memory
//   mem_addr, mem_wdata      address / write data to memory
//   mem_rdata                combinational read data from memory
//   stat_grants, stat_stalls host grant / stalled-grant counters
// -----------------------------------------------------------------------------
module misao_mem_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_en_read,
  input  logic              core_en_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en_read,
  output logic              mem_en_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_grants,
  output logic [15:0]       stat_stalls
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  // Last wait count before the host is forced onto the bus.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             core_active;
  logic             in_grant;

  assign core_active = core_en_read | core_en_write;
  assign in_grant    = (state == S_GRANT);

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_IDLE: begin
        if (host_req && !core_active) begin
          state_nxt = S_GRANT;
        end else if (host_req) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = {CNT_W{1'b0}};
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!host_req) begin
          // Abandoned request: no ack is ever issued for it.
          state_nxt = S_IDLE;
        end else if (!core_active) begin
          state_nxt = S_GRANT;
        end else if (wait_cnt == CNT_LAST) begin
          // Starvation limit reached: host goes in, core is stalled.
          state_nxt = S_GRANT;
        end else begin
          wait_cnt_nxt = wait_cnt + CNT_ONE;
        end
      end
      // A dropped host_req is ignored here; the access always completes.
      S_GRANT: state_nxt = S_ACK;
      // ACK always returns to IDLE so the core gets at least one bus cycle
      // between consecutive host accesses.
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter, host acknowledge and host read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= {CNT_W{1'b0}};
      host_ack   <= 1'b0;
      host_rdata <= {DATA_W{1'b0}};
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      // ACK is always the cycle after GRANT, so the pulse is a registered GRANT.
      host_ack <= in_grant;
      if (in_grant && !host_we) begin
        host_rdata <= mem_rdata;
      end else begin
        host_rdata <= host_rdata;
      end
    end
  end

  // Memory bus mux: host owns the bus only during GRANT.
  always_comb begin
    if (in_grant) begin
      mem_en_read  = !host_we;
      mem_en_write = host_we;
      mem_addr     = host_addr;
      mem_wdata    = host_wdata;
      core_stall   = core_active;
    end else begin
      mem_en_read  = core_en_read;
      mem_en_write = core_en_write;
      mem_addr     = core_addr;
      mem_wdata    = core_wdata;
      core_stall   = 1'b0;
    end
  end

  assign core_rdata = mem_rdata;

`ifdef ARB_STATS_EN
  logic [15:0] grants_cnt;
  logic [15:0] stalls_cnt;

  // Saturating statistics: grants counted on GRANT entry, stalls counted
  // when the core is actually held off during the GRANT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_cnt <= 16'h0000;
      stalls_cnt <= 16'h0000;
    end else begin
      if ((state_nxt == S_GRANT) && (grants_cnt != 16'hFFFF)) begin
        grants_cnt <= grants_cnt + 16'h0001;
      end else begin
        grants_cnt <= grants_cnt;
      end
      if (in_grant && core_active && (stalls_cnt != 16'hFFFF)) begin
        stalls_cnt <= stalls_cnt + 16'h0001;
      end else begin
        stalls_cnt <= stalls_cnt;
      end
    end
  end

  assign stat_grants = grants_cnt;
  assign stat_stalls = stalls_cnt;
`else
  assign stat_grants = 16'h0000;
  assign stat_stalls = 16'h0000;
`endif

endmodule
